// File: rtl/arb_pkg.sv
// Shared arbiter definitions: phase encoding and error codes.
// The error code is laid out as {hold_err, timeout_err}, so it can be
// assigned directly onto the two error pulse registers.
package arb_pkg;

   localparam int unsigned ERR_W = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACTIVE1 = 2'b01,
      ACTIVE2 = 2'b10,
      RECOVER = 2'b11
   } phase_t;

   localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [ERR_W-1:0] ERR_HOLD    = 2'b10;

endpackage

// File: rtl/rr_phase_arbiter_if.sv
// Requester/resource side bundle of rr_phase_arbiter.
//   req          : per-requester request level
//   ready / done : resource phase-advance inputs
//   grant        : one-hot grant or zero
//   grant_id     : current or last granted index
//   state        : current phase
//   timeout_err  : setup timeout pulse
//   hold_err     : forced-release pulse
// master drives req/ready/done; slave is the arbiter.
interface rr_phase_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   import arb_pkg::*;

   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic             ready;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   phase_t           state;
   logic             timeout_err;
   logic             hold_err;

   modport master (
      output req, ready, done,
      input  grant, grant_id, state, timeout_err, hold_err
   );

   modport slave (
      input  req, ready, done,
      output grant, grant_id, state, timeout_err, hold_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req      : request vector
//   last_idx : index granted last (lowest priority this round)
//   valid    : some request is set
//   next_idx : first set bit scanning upward from last_idx+1 with wrap
module rr_pick #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_idx,
   output logic             valid,
   output logic [ID_W-1:0]  next_idx
);

   // Offsets 1..N_REQ visit every requester once, ending at last_idx itself.
   always_comb begin
      int unsigned cand;
      cand     = 0;
      valid    = 1'b0;
      next_idx = last_idx;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = (32'(last_idx) + i) % N_REQ;
         if (!valid && req[ID_W'(cand)]) begin
            valid    = 1'b1;
            next_idx = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_phase_arbiter.sv
// Round-robin owner of a shared two-phase resource.
// Each grant walks IDLE -> ACTIVE1 (setup, wait ready) -> ACTIVE2
// (transfer, wait done). Setup is bounded by SETUP_TIMEOUT (abort through
// RECOVER), transfer by HOLD_MAX (forced release).
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : rr_phase_arbiter_if slave (req/ready/done in,
//                grant/grant_id/state/timeout_err/hold_err out, registered)
module rr_phase_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned SETUP_TIMEOUT = 16,
   parameter int unsigned HOLD_MAX      = 8
) (
   input  logic              clk,
   input  logic              reset,
   rr_phase_arbiter_if.slave bus
);

   localparam int unsigned ID_W = $clog2(N_REQ);
   localparam int unsigned ST_W = $clog2(SETUP_TIMEOUT + 1);
   localparam int unsigned HD_W = $clog2(HOLD_MAX + 1);

   phase_t           state_r;
   logic [N_REQ-1:0] grant_r;
   logic [ID_W-1:0]  grant_id_r;
   logic             timeout_err_r;
   logic             hold_err_r;
   logic [ST_W-1:0]  setup_cnt;
   logic [HD_W-1:0]  hold_cnt;

   logic             pick_valid;
   logic [ID_W-1:0]  pick_idx;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req      (bus.req),
      .last_idx (grant_id_r),
      .valid    (pick_valid),
      .next_idx (pick_idx)
   );

   // Phase FSM; all outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         grant_r       <= '0;
         grant_id_r    <= ID_W'(N_REQ - 1);
         timeout_err_r <= 1'b0;
         hold_err_r    <= 1'b0;
         setup_cnt     <= '0;
         hold_cnt      <= '0;
      end else begin
         {hold_err_r, timeout_err_r} <= ERR_NONE;
         case (state_r)
            IDLE: begin
               if (pick_valid) begin
                  grant_id_r <= pick_idx;
                  grant_r    <= N_REQ'(1) << pick_idx;
                  setup_cnt  <= '0;
                  state_r    <= ACTIVE1;
               end
            end
            // Withdrawal beats ready, ready beats timeout.
            ACTIVE1: begin
               if (!bus.req[grant_id_r]) begin
                  grant_r <= '0;
                  state_r <= IDLE;
               end else if (bus.ready) begin
                  hold_cnt <= '0;
                  state_r  <= ACTIVE2;
               end else if (setup_cnt == ST_W'(SETUP_TIMEOUT - 1)) begin
                  grant_r                     <= '0;
                  {hold_err_r, timeout_err_r} <= ERR_TIMEOUT;
                  state_r                     <= RECOVER;
               end else begin
                  setup_cnt <= setup_cnt + ST_W'(1);
               end
            end
            // The transfer owns the resource: req is not looked at here.
            ACTIVE2: begin
               if (bus.done) begin
                  grant_r <= '0;
                  state_r <= IDLE;
               end else if (hold_cnt == HD_W'(HOLD_MAX - 1)) begin
                  grant_r                     <= '0;
                  {hold_err_r, timeout_err_r} <= ERR_HOLD;
                  state_r                     <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HD_W'(1);
               end
            end
            RECOVER: begin
               state_r <= IDLE;
            end
            default: begin
               grant_r <= '0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.state       = state_r;
   assign bus.grant       = grant_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.timeout_err = timeout_err_r;
   assign bus.hold_err    = hold_err_r;

   // Structural invariants.
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
      $onehot0(grant_r));

   a_grant_matches_state : assert property (@(posedge clk) disable iff (reset)
      (grant_r != '0) == (state_r == ACTIVE1 || state_r == ACTIVE2));

   // Counters bound the time spent in each active phase.
   a_setup_bounded : assert property (@(posedge clk) disable iff (reset)
      (state_r == ACTIVE1) |-> (setup_cnt < ST_W'(SETUP_TIMEOUT)));

   a_hold_bounded : assert property (@(posedge clk) disable iff (reset)
      (state_r == ACTIVE2) |-> (hold_cnt < HD_W'(HOLD_MAX)));

endmodule

// File: tb/tb_rr_phase_arbiter.sv
// Directed bench for rr_phase_arbiter (N_REQ=4, SETUP_TIMEOUT=16, HOLD_MAX=8).
module tb_rr_phase_arbiter;
   import arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   rr_phase_arbiter_if #(.N_REQ(4)) bus ();

   rr_phase_arbiter #(
      .N_REQ         (4),
      .SETUP_TIMEOUT (16),
      .HOLD_MAX      (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] es, input logic [3:0] eg,
                             input logic [1:0] eid, input logic eto, input logic eho);
      check_eq({tag, ".state"}, 32'(bus.state), 32'(es));
      check_eq({tag, ".grant"}, 32'(bus.grant), 32'(eg));
      check_eq({tag, ".grant_id"}, 32'(bus.grant_id), 32'(eid));
      check_eq({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(eto));
      check_eq({tag, ".hold_err"}, 32'(bus.hold_err), 32'(eho));
   endtask

   // Apply ready/done, clock once, then check everything after the edge.
   task automatic step(input string tag, input logic r, input logic d, input logic [1:0] es,
                       input logic [3:0] eg, input logic [1:0] eid, input logic eto,
                       input logic eho);
      bus.ready = r;
      bus.done  = d;
      tick();
      check_outs(tag, es, eg, eid, eto, eho);
   endtask

   initial begin
      reset     = 1'b1;
      bus.req   = '0;
      bus.ready = 1'b0;
      bus.done  = 1'b0;
      repeat (2) tick();
      check_outs("reset", 2'b00, 4'b0000, 2'd3, 1'b0, 1'b0);
      reset = 1'b0;

      // Single request: ready in third setup cycle, done in third transfer cycle.
      bus.req = 4'b0001;
      for (int i = 0; i < 3; i++) step("single_a1", 1'b0, 1'b0, 2'b01, 4'b0001, 2'd0, 1'b0, 1'b0);
      step("single_a2", 1'b1, 1'b0, 2'b10, 4'b0001, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("single_a2", 1'b0, 1'b0, 2'b10, 4'b0001, 2'd0, 1'b0, 1'b0);
      bus.req = '0;
      step("single_end", 1'b0, 1'b1, 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Asynchronous reset between edges restores the pointer.
      reset = 1'b1;
      #2;
      check_outs("reset_pulse", 2'b00, 4'b0000, 2'd3, 1'b0, 1'b0);
      reset = 1'b0;

      // Round robin with immediate ready/done: ids 0,1,2,3,0.
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step("rr_a1", 1'b1, 1'b1, 2'b01, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, 1'b0);
         step("rr_a2", 1'b1, 1'b1, 2'b10, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, 1'b0);
         if (k == 4) bus.req = '0;
         step("rr_idle", 1'b1, 1'b1, 2'b00, 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      end

      // Setup timeout on requester 2; requester 3 wins next.
      bus.req = 4'b0100;
      for (int i = 0; i < 16; i++) step("to_a1", 1'b0, 1'b0, 2'b01, 4'b0100, 2'd2, 1'b0, 1'b0);
      bus.req = 4'b1100;
      step("to_recover", 1'b0, 1'b0, 2'b11, 4'b0000, 2'd2, 1'b1, 1'b0);
      step("to_idle", 1'b0, 1'b0, 2'b00, 4'b0000, 2'd2, 1'b0, 1'b0);
      step("to_next", 1'b0, 1'b0, 2'b01, 4'b1000, 2'd3, 1'b0, 1'b0);
      bus.req = '0;
      step("wd3", 1'b1, 1'b0, 2'b00, 4'b0000, 2'd3, 1'b0, 1'b0);

      // Hold limit: eight transfer cycles then forced release.
      bus.req = 4'b0001;
      step("hold_a1", 1'b0, 1'b0, 2'b01, 4'b0001, 2'd0, 1'b0, 1'b0);
      step("hold_a2", 1'b1, 1'b0, 2'b10, 4'b0001, 2'd0, 1'b0, 1'b0);
      bus.req = '0;
      for (int i = 0; i < 7; i++) step("hold_a2", 1'b0, 1'b0, 2'b10, 4'b0001, 2'd0, 1'b0, 1'b0);
      step("hold_rel", 1'b0, 1'b0, 2'b00, 4'b0000, 2'd0, 1'b0, 1'b1);
      step("hold_after", 1'b0, 1'b0, 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Withdrawal of req[1] together with ready: withdrawal wins.
      bus.req = 4'b0010;
      step("wd_a1", 1'b0, 1'b0, 2'b01, 4'b0010, 2'd1, 1'b0, 1'b0);
      bus.req = '0;
      step("wd_idle", 1'b1, 1'b0, 2'b00, 4'b0000, 2'd1, 1'b0, 1'b0);
      step("wd_stay", 1'b0, 1'b0, 2'b00, 4'b0000, 2'd1, 1'b0, 1'b0);

      // ready on the timeout cycle, then done on the hold-limit cycle.
      bus.req = 4'b0100;
      for (int i = 0; i < 16; i++) step("edge_a1", 1'b0, 1'b0, 2'b01, 4'b0100, 2'd2, 1'b0, 1'b0);
      step("edge_ready", 1'b1, 1'b0, 2'b10, 4'b0100, 2'd2, 1'b0, 1'b0);
      bus.req = '0;
      for (int i = 0; i < 7; i++) step("edge_a2", 1'b0, 1'b0, 2'b10, 4'b0100, 2'd2, 1'b0, 1'b0);
      step("edge_done", 1'b0, 1'b1, 2'b00, 4'b0000, 2'd2, 1'b0, 1'b0);

      // Reset in the middle of ACTIVE2 with grant_id=2.
      bus.req = 4'b0100;
      step("mid_a1", 1'b0, 1'b0, 2'b01, 4'b0100, 2'd2, 1'b0, 1'b0);
      step("mid_a2", 1'b1, 1'b0, 2'b10, 4'b0100, 2'd2, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check_outs("mid_reset", 2'b00, 4'b0000, 2'd3, 1'b0, 1'b0);
      tick();
      reset   = 1'b0;
      bus.req = 4'b1111;
      step("post_reset", 1'b0, 1'b0, 2'b01, 4'b0001, 2'd0, 1'b0, 1'b0);
      bus.req = '0;
      step("post_wd", 1'b0, 1'b0, 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_phase_arbiter.md
# rr_phase_arbiter

Round-robin controller that shares one two-phase resource between `N_REQ` requesters. Each grant runs through a fixed phase sequence: IDLE → ACTIVE1 (setup, waiting for the resource's `ready`) → ACTIVE2 (transfer, waiting for `done`). A bounded setup watchdog guarantees that every entry into ACTIVE1 leaves it within `SETUP_TIMEOUT` cycles, so the block never stalls in setup. It sits between the requesting agents and the shared-resource state machine and drives that resource's phase advances.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `SETUP_TIMEOUT`, 16: maximum number of cycles spent in ACTIVE1 before abort; ≥ 2.
- `HOLD_MAX`, 8: maximum number of cycles spent in ACTIVE2 before forced release; ≥ 1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  N_REQ  request per requester; level-sensitive.
- `ready`  in  1  resource ready; advances ACTIVE1 → ACTIVE2.
- `done`  in  1  transfer complete; ends ACTIVE2.
- `grant`  out  N_REQ  one-hot grant, or zero; registered.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester; registered.
- `state`  out  2  phase: IDLE=2'b00, ACTIVE1=2'b01, ACTIVE2=2'b10, RECOVER=2'b11.
- `timeout_err`  out  1  one-cycle pulse on setup timeout.
- `hold_err`  out  1  one-cycle pulse on forced release from ACTIVE2.

## Operation
- **Reset values:**
  - `state` = IDLE
  - `grant` = 0
  - `grant_id` = N_REQ-1, so requester 0 has priority first
  - `timeout_err` = 0, `hold_err` = 0
  - both counters = 0
- **IDLE:** if `req` is nonzero, pick the first set bit scanning upward from `grant_id+1` with wrap-around. Load `grant_id`, set the corresponding `grant` bit, clear the setup counter, and go to ACTIVE1. If `req` is zero, stay in IDLE.
- **ACTIVE1:** evaluated in priority order:
  1. If `req[grant_id]` = 0 (withdrawn), go to IDLE and clear `grant`. No error is raised.
  2. Else if `ready` = 1, go to ACTIVE2 and clear the hold counter.
  3. Else if setup counter = SETUP_TIMEOUT-1, go to RECOVER, clear `grant`, and pulse `timeout_err`.
  4. Else increment the setup counter.
- **ACTIVE2:**
  - If `done` = 1, go to IDLE and clear `grant`.
  - Else if hold counter = HOLD_MAX-1, go to IDLE, clear `grant`, and pulse `hold_err`.
  - Else increment the hold counter.
  - `req` withdrawal is ignored in ACTIVE2; the transfer owns the resource.
- **RECOVER:** one cycle with `grant` = 0, then unconditionally go to IDLE.
- **Fairness:** `grant_id` advances only on a new grant. The requester granted last has the lowest priority in the next arbitration, so any requester that holds `req` high is granted within N_REQ arbitrations.
- **Counters:** width is $clog2(max+1). They saturate only via the state exit and never wrap.
- **Liveness:** every ACTIVE1 entry reaches ACTIVE2, IDLE or RECOVER within SETUP_TIMEOUT cycles. Every ACTIVE2 entry reaches IDLE within HOLD_MAX cycles.

## Timing
- `req` sampled in IDLE at edge k gives `grant` and `state`=ACTIVE1 visible after edge k.
- Minimum back-to-back grant spacing is 3 cycles: IDLE, ACTIVE1, ACTIVE2 with `ready` and `done` both immediate.
- **Simultaneous `ready` and withdrawal in ACTIVE1:** withdrawal wins.
- **Simultaneous `ready` and timeout:** `ready` wins; no `timeout_err`.
- **Simultaneous `done` and hold limit:** `done` wins; no `hold_err`.
- Each error pulse is high for exactly the one cycle coincident with the first cycle of RECOVER or IDLE.
- **Reset mid-operation:** all outputs take their reset values immediately (asynchronous), and the round-robin pointer returns to N_REQ-1.

## Structure
- **Shared package `arb_pkg`:** `phase_t` enum (IDLE, ACTIVE1, ACTIVE2, RECOVER as encoded above), plus the error-code localparams.
- **Sub-module `rr_pick`:** combinational round-robin selector. Inputs: `req` and the last index. Outputs: `valid` and the next index. It is reused by other arbiters in the codebase.
- Embedded concurrent assertions, disabled during `reset`:
  - `grant` is one-hot0.
  - ACTIVE1 leads to ACTIVE2, IDLE or RECOVER within SETUP_TIMEOUT cycles.
  - ACTIVE2 leads to IDLE within HOLD_MAX cycles.
  - `grant` is nonzero exactly when `state` is ACTIVE1 or ACTIVE2.

## Test plan
- **Single request:** `req`=4'b0001, `ready` after 2 cycles, then `done` after 3 cycles → grant=0001 throughout. `state` sequence is 01,01,01,10,10,10,00. No error pulses.
- **Round-robin:** `req`=4'b1111 held, `ready`=`done`=1 → `grant_id` sequence 0,1,2,3,0, each grant lasting 2 cycles.
- **Setup timeout:** `req`=4'b0100, `ready`=0 → after 16 cycles in ACTIVE1, `state`=11 with `timeout_err`=1 for 1 cycle. Next cycle `state`=00. Requester 3 is next if requesting.
- **Hold limit:** grant reaches ACTIVE2, `done`=0 → after 8 cycles `state`=00 and `hold_err` pulses once.
- **Withdrawal:** `req[1]` dropped in ACTIVE1 with `ready` high on the same cycle → next state is IDLE, `grant`=0, no errors.
- **Reset mid-ACTIVE2:** with `grant_id`=2, assert `reset` → `grant`=0, `state`=00, `grant_id`=3 immediately. After release, `req`=4'b1111 grants requester 0 first.
